mux16_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 16:1 multiplexer between 16 requesters. It tracks ownership of the shared mux with a per-requester request/done handshake. It drives the mux's 4-bit select and a one-hot grant vector, and forcibly reclaims the mux from a requester that holds it too long. It sits directly in front of the 16x1 mux select input.

---
 rtl/mux16_rr_arbiter.sv | 112 +++++++++++
 tb/tb_mux16_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 16:1 mux. Grants one
// requester at a time, releases on done / request drop / MAX_HOLD expiry.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  sel_q, sel_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;

    logic        found;
    logic [3:0]  pick;
    logic [3:0]  idx;
    logic        hold_hit;
    logic        owner_drop;
    logic        release_now;

    // Rotating priority scan: first set request at or after ptr, wrapping mod 16.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign hold_hit    = (MAX_HOLD != 0) && (hold_q == MAX_HOLD_C);
    assign owner_drop  = !req[sel_q];
    assign release_now = done || owner_drop || hold_hit;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 16'b1 << pick;
                    sel_d   = pick;
                    valid_d = 1'b1;
                    hold_d  = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = sel_q + 4'd1;
                    state_d   = IDLE;
                    // A timeout is flagged only when nothing else would have released.
                    timeout_d = hold_hit && !done && !owner_drop;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: one main instance (MAX_HOLD=255) plus
// short-hold instances (4 and 2) for the revoke and simultaneous-release cases.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst_n;

    logic [15:0] req,  req4,  req2;
    logic        done, done4, done2;
    logic [15:0] grant, grant4, grant2;
    logic [3:0]  sel, sel4, sel2;
    logic        valid, valid4, valid2;
    logic        timeout, timeout4, timeout2;

    int total;
    int bad;

    mux16_rr_arbiter #(.MAX_HOLD(255)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .sel(sel), .valid(valid), .timeout(timeout)
    );

    mux16_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .done(done4),
        .grant(grant4), .sel(sel4), .valid(valid4), .timeout(timeout4)
    );

    mux16_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .done(done2),
        .grant(grant2), .sel(sel2), .valid(valid2), .timeout(timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = '0; done = 1'b0;
        req4 = '0; done4 = 1'b0;
        req2 = '0; done2 = 1'b0;
        step; step;
        total++; if (grant !== 16'h0 || sel !== 4'd0 || valid !== 1'b0 || timeout !== 1'b0) begin
            bad++; $display("FAIL reset_init got grant=%h sel=%0d valid=%b timeout=%b exp all 0", grant, sel, valid, timeout);
        end
        rst_n = 1'b1;
        req = 16'h0020;
        step;
        total++; if (grant !== 16'h0020 || sel !== 4'd5 || valid !== 1'b1) begin
            bad++; $display("FAIL reset_pre_grant got grant=%h sel=%0d valid=%b exp 0020/5/1", grant, sel, valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (grant !== 16'h0 || sel !== 4'd0 || valid !== 1'b0 || timeout !== 1'b0) begin
            bad++; $display("FAIL reset_async got grant=%h sel=%0d valid=%b timeout=%b exp all 0", grant, sel, valid, timeout);
        end
        step;
        rst_n = 1'b1;
        req = 16'h0001;
        step;
        total++; if (grant !== 16'h0001 || sel !== 4'd0 || valid !== 1'b1) begin
            bad++; $display("FAIL reset_ptr0 got grant=%h sel=%0d valid=%b exp 0001/0/1", grant, sel, valid);
        end
        done = 1'b1;
        step;
        done = 1'b0;
        req = '0;
        total++; if (valid !== 1'b0 || grant !== 16'h0) begin
            bad++; $display("FAIL reset_release got valid=%b grant=%h exp 0/0000", valid, grant);
        end
    endtask

    task automatic test_single;
        // ptr is 1 here; requester 5 is the only one asking.
        req = 16'h0020;
        step;
        total++; if (grant !== 16'h0020 || sel !== 4'd5 || valid !== 1'b1) begin
            bad++; $display("FAIL single_grant got grant=%h sel=%0d valid=%b exp 0020/5/1", grant, sel, valid);
        end
        done = 1'b1;
        step;
        done = 1'b0;
        req = 16'h0041;
        total++; if (valid !== 1'b0 || grant !== 16'h0 || sel !== 4'd5 || timeout !== 1'b0) begin
            bad++; $display("FAIL single_release got valid=%b grant=%h sel=%0d timeout=%b exp 0/0000/5/0", valid, grant, sel, timeout);
        end
        step;
        total++; if (sel !== 4'd6 || grant !== 16'h0040) begin
            bad++; $display("FAIL single_ptr6 got sel=%0d grant=%h exp 6/0040", sel, grant);
        end
        done = 1'b1;
        req = '0;
        step;
        done = 1'b0;
    endtask

    task automatic test_fairness;
        logic [3:0] exp_sel;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 16'hFFFF;
        for (int i = 0; i < 18; i++) begin
            exp_sel = 4'(i % 16);
            step;
            total++; if (valid !== 1'b1 || sel !== exp_sel || grant !== (16'h1 << exp_sel)) begin
                bad++; $display("FAIL fair_grant[%0d] got valid=%b sel=%0d grant=%h exp 1/%0d", i, valid, sel, grant, exp_sel);
            end
            done = 1'b1;
            step;
            done = 1'b0;
            total++; if (valid !== 1'b0 || grant !== 16'h0) begin
                bad++; $display("FAIL fair_gap[%0d] got valid=%b grant=%h exp 0/0000", i, valid, grant);
            end
        end
        req = '0;
        step;
    endtask

    task automatic test_wrap;
        // ptr is 2 after the fairness run.
        req = 16'h4000;
        step;
        total++; if (sel !== 4'd14 || valid !== 1'b1) begin
            bad++; $display("FAIL wrap_14 got sel=%0d valid=%b exp 14/1", sel, valid);
        end
        done = 1'b1;
        req = 16'h8008;
        step;
        done = 1'b0;
        step;
        total++; if (sel !== 4'd15 || grant !== 16'h8000 || valid !== 1'b1) begin
            bad++; $display("FAIL wrap_15 got sel=%0d grant=%h valid=%b exp 15/8000/1", sel, grant, valid);
        end
        done = 1'b1;
        step;
        done = 1'b0;
        step;
        total++; if (sel !== 4'd3 || grant !== 16'h0008 || valid !== 1'b1) begin
            bad++; $display("FAIL wrap_3 got sel=%0d grant=%h valid=%b exp 3/0008/1", sel, grant, valid);
        end
        done = 1'b1;
        req = '0;
        step;
        done = 1'b0;
    endtask

    task automatic test_timeout;
        req4 = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            step;
            total++; if (valid4 !== 1'b1 || sel4 !== 4'd2 || timeout4 !== 1'b0) begin
                bad++; $display("FAIL to_hold[%0d] got valid=%b sel=%0d timeout=%b exp 1/2/0", i, valid4, sel4, timeout4);
            end
        end
        step;
        total++; if (valid4 !== 1'b0 || timeout4 !== 1'b1 || grant4 !== 16'h0) begin
            bad++; $display("FAIL to_revoke got valid=%b timeout=%b grant=%h exp 0/1/0000", valid4, timeout4, grant4);
        end
        req4 = 16'h0104;
        step;
        total++; if (sel4 !== 4'd8 || grant4 !== 16'h0100 || timeout4 !== 1'b0) begin
            bad++; $display("FAIL to_next got sel=%0d grant=%h timeout=%b exp 8/0100/0", sel4, grant4, timeout4);
        end
        done4 = 1'b1;
        req4 = '0;
        step;
        done4 = 1'b0;
        total++; if (valid4 !== 1'b0 || timeout4 !== 1'b0) begin
            bad++; $display("FAIL to_done_release got valid=%b timeout=%b exp 0/0", valid4, timeout4);
        end
    endtask

    task automatic test_req_drop;
        // ptr is 4; only requester 3 asks, so the scan wraps to it.
        req = 16'h0008;
        step;
        step;
        total++; if (sel !== 4'd3 || valid !== 1'b1) begin
            bad++; $display("FAIL drop_grant got sel=%0d valid=%b exp 3/1", sel, valid);
        end
        req = '0;
        step;
        total++; if (valid !== 1'b0 || timeout !== 1'b0 || grant !== 16'h0) begin
            bad++; $display("FAIL drop_release got valid=%b timeout=%b grant=%h exp 0/0/0000", valid, timeout, grant);
        end
    endtask

    task automatic test_simultaneous;
        req2 = 16'h0002;
        step;
        step;
        total++; if (valid2 !== 1'b1 || sel2 !== 4'd1) begin
            bad++; $display("FAIL sim_hold2 got valid=%b sel=%0d exp 1/1", valid2, sel2);
        end
        done2 = 1'b1;
        step;
        done2 = 1'b0;
        total++; if (valid2 !== 1'b0 || timeout2 !== 1'b0) begin
            bad++; $display("FAIL sim_done_max got valid=%b timeout=%b exp 0/0", valid2, timeout2);
        end
        // Same owner again, this time with no done: revoked after 2 cycles.
        step;
        total++; if (valid2 !== 1'b1 || sel2 !== 4'd1) begin
            bad++; $display("FAIL sim_regrant got valid=%b sel=%0d exp 1/1", valid2, sel2);
        end
        step;
        step;
        total++; if (valid2 !== 1'b0 || timeout2 !== 1'b1) begin
            bad++; $display("FAIL sim_timeout2 got valid=%b timeout=%b exp 0/1", valid2, timeout2);
        end
        req2 = '0;
        step;
        total++; if (timeout2 !== 1'b0 || valid2 !== 1'b0) begin
            bad++; $display("FAIL sim_pulse_width got timeout=%b valid=%b exp 0/0", timeout2, valid2);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_single;
        test_fairness;
        test_wrap;
        test_timeout;
        test_req_drop;
        test_simultaneous;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
